// File: rtl/legv8_pkg.sv
// Shared LEGv8 opcode, ALUOp and ALU-control encodings for the control/data-memory slice.
package legv8_pkg;

    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;
    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [3:0] ALUC_AND   = 4'b0000;
    localparam logic [3:0] ALUC_ORR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD   = 4'b0010;
    localparam logic [3:0] ALUC_SUB   = 4'b0110;
    localparam logic [3:0] ALUC_PASSB = 4'b0111;
    localparam logic [3:0] ALUC_INV   = 4'b1111;

    // CBZ carries a 19-bit offset whose top 3 bits overlap opcode[2:0].
    function automatic logic is_cbz(input logic [10:0] op);
        return (op[10:3] == OP_CBZ_PFX);
    endfunction

endpackage

// File: rtl/legv8_data_ram.sv
// DEPTH x 64-bit data memory: asynchronous clear, synchronous write, combinational read.
module legv8_data_ram
    import legv8_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] r_mem [DEPTH];

    // Reset wipes every word; otherwise store one full word per enabled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule

// File: rtl/legv8_ctrl_datamem.sv
// Single-cycle LEGv8 main control, ALU control and data memory.
module legv8_ctrl_datamem
    import legv8_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ADDR_LSB = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic        reg_to_loc,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] w_idx;
    logic [63:0]   w_ram_rdata;
    logic          w_unused_addr;

    // Upper bits wrap and the byte offset is dropped; no alignment trap.
    assign w_idx         = mem_addr[ADDR_LSB +: AW];
    assign w_unused_addr = ^{mem_addr[63:ADDR_LSB+AW], mem_addr[ADDR_LSB-1:0]};

    // Main control decode; unknown opcodes leave every strobe low.
    always_comb begin
        reg_to_loc = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALUOP_ADD;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                alu_op    = ALUOP_RTYPE;
                reg_write = 1'b1;
            end
            OP_LDUR: begin
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                reg_write  = 1'b1;
            end
            OP_STUR: begin
                reg_to_loc = 1'b1;
                mem_write  = 1'b1;
                alu_src    = 1'b1;
            end
            default: begin
                if (is_cbz(opcode)) begin
                    reg_to_loc = 1'b1;
                    branch     = 1'b1;
                    alu_op     = ALUOP_PASSB;
                end else begin
                    branch = 1'b0;
                end
            end
        endcase
    end

    // ALU operation select from ALUOp, falling back to the R-type opcode.
    always_comb begin
        alu_ctrl = ALUC_INV;
        case (alu_op)
            ALUOP_ADD:   alu_ctrl = ALUC_ADD;
            ALUOP_PASSB: alu_ctrl = ALUC_PASSB;
            default: begin
                case (opcode)
                    OP_ADD:  alu_ctrl = ALUC_ADD;
                    OP_SUB:  alu_ctrl = ALUC_SUB;
                    OP_AND:  alu_ctrl = ALUC_AND;
                    OP_ORR:  alu_ctrl = ALUC_ORR;
                    default: alu_ctrl = ALUC_INV;
                endcase
            end
        endcase
    end

    legv8_data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (mem_write),
        .idx   (w_idx),
        .wdata (mem_wdata),
        .rdata (w_ram_rdata)
    );

    assign mem_rdata = mem_read ? w_ram_rdata : 64'd0;

endmodule

// File: tb/tb_legv8_ctrl_datamem.sv
// Self-checking bench: per-cycle model comparison plus hand-computed directed checks.
module tb_legv8_ctrl_datamem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] opcode = 11'd0;
    logic [63:0] mem_addr = 64'd0;
    logic [63:0] mem_wdata = 64'd0;
    logic        reg_to_loc, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;

    legv8_ctrl_datamem dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .reg_to_loc (reg_to_loc),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_ctrl   (alu_ctrl),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Instruction class by mnemonic, then a lookup table of controls.
    function automatic string mnem(input logic [10:0] op);
        if (op == T_ADD) return "ADD";
        if (op == T_SUB) return "SUB";
        if (op == T_AND) return "AND";
        if (op == T_ORR) return "ORR";
        if (op == T_LDUR) return "LDUR";
        if (op == T_STUR) return "STUR";
        if ((op >> 3) == 11'd180) return "CBZ";
        return "UNDEF";
    endfunction

    // Returns {r2l,br,mrd,m2r,aluop[1:0],mwr,src,rw, alu_ctrl[3:0]}.
    function automatic logic [12:0] model_ctl(input logic [10:0] op);
        case (mnem(op))
            "ADD":   return {9'b0_0_0_0_10_0_0_1, 4'b0010};
            "SUB":   return {9'b0_0_0_0_10_0_0_1, 4'b0110};
            "AND":   return {9'b0_0_0_0_10_0_0_1, 4'b0000};
            "ORR":   return {9'b0_0_0_0_10_0_0_1, 4'b0001};
            "LDUR":  return {9'b0_0_1_1_00_0_1_1, 4'b0010};
            "STUR":  return {9'b1_0_0_0_00_1_1_0, 4'b0010};
            "CBZ":   return {9'b1_1_0_0_01_0_0_0, 4'b0111};
            default: return {9'b0_0_0_0_00_0_0_0, 4'b0010};
        endcase
    endfunction

    logic [63:0] m_mem [32];

    function automatic int widx(input logic [63:0] a);
        return int'((a / 64'd8) % 64'd32);
    endfunction

    // Reference memory: cleared by reset, written by stores on clock edges.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= 64'd0;
        end else if (mnem(opcode) == "STUR") begin
            m_mem[widx(mem_addr)] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_ctl();
        return {reg_to_loc, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write};
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [12:0] e;
            logic [63:0] erd;
            e = model_ctl(opcode);
            erd = (mnem(opcode) == "LDUR" && !reset) ? m_mem[widx(mem_addr)] : 64'd0;
            chk("model_ctl", {55'd0, dut_ctl()}, {55'd0, e[12:4]});
            chk("model_alu_ctrl", {60'd0, alu_ctrl}, {60'd0, e[3:0]});
            chk("model_rdata", mem_rdata, erd);
        end
    end

    task automatic drive(input logic [10:0] op, input logic [63:0] a, input logic [63:0] d);
        @(posedge clk);
        #1;
        opcode = op;
        mem_addr = a;
        mem_wdata = d;
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        drive(T_LDUR, 64'h0, 64'h0);
        chk("reset_rdata", mem_rdata, 64'd0);
        reset = 1'b0;

        // R-type decode and ALU control
        drive(T_ADD, 64'h0, 64'h0);
        chk("add_ctl", {55'd0, dut_ctl()}, {55'd0, 9'b0_0_0_0_10_0_0_1});
        chk("add_aluc", {60'd0, alu_ctrl}, 64'h2);
        drive(T_SUB, 64'h0, 64'h0);
        chk("sub_aluc", {60'd0, alu_ctrl}, 64'h6);
        drive(T_AND, 64'h0, 64'h0);
        chk("and_aluc", {60'd0, alu_ctrl}, 64'h0);
        drive(T_ORR, 64'h0, 64'h0);
        chk("orr_aluc", {60'd0, alu_ctrl}, 64'h1);

        // Store then load
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        drive(T_STUR, 64'h10, 64'hDEADBEEF_CAFEF00D);
        chk("stur_mwr", {63'd0, mem_write}, 64'd1);
        chk("stur_aluc", {60'd0, alu_ctrl}, 64'h2);
        drive(T_LDUR, 64'h10, 64'h0);
        chk("ldur_rdata", mem_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("ldur_m2r_rw", {62'd0, mem_to_reg, reg_write}, 64'd3);
        drive(T_LDUR, 64'h08, 64'h0);
        chk("ldur_empty", mem_rdata, 64'd0);

        // CBZ variants must not write
        drive(11'b10110100000, 64'h10, 64'h1111);
        chk("cbz0_ctl", {55'd0, dut_ctl()}, {55'd0, 9'b1_1_0_0_01_0_0_0});
        chk("cbz0_aluc", {60'd0, alu_ctrl}, 64'h7);
        drive(11'b10110100111, 64'h10, 64'h2222);
        chk("cbz7_ctl", {55'd0, dut_ctl()}, {55'd0, 9'b1_1_0_0_01_0_0_0});
        drive(T_LDUR, 64'h10, 64'h0);
        chk("cbz_nowrite", mem_rdata, 64'hDEADBEEF_CAFEF00D);

        // Address wrap and ignored byte offset
        drive(T_STUR, 64'h118, 64'hA5A5_5A5A_0F0F_F0F0);
        drive(T_LDUR, 64'h18, 64'h0);
        chk("wrap_rdata", mem_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        drive(T_LDUR, 64'h1B, 64'h0);
        chk("offset_rdata", mem_rdata, 64'hA5A5_5A5A_0F0F_F0F0);

        // Asynchronous reset clears data mid-cycle and blocks writes
        drive(T_STUR, 64'h28, 64'h1234);
        drive(T_LDUR, 64'h28, 64'h0);
        chk("w5_rdata", mem_rdata, 64'h1234);
        #1 reset = 1'b1;
        #1;
        chk("w5_async_clr", mem_rdata, 64'd0);
        drive(T_STUR, 64'h28, 64'h5555);
        drive(T_LDUR, 64'h28, 64'h0);
        chk("w5_blocked_in_rst", mem_rdata, 64'd0);
        reset = 1'b0;
        drive(T_LDUR, 64'h28, 64'h0);
        chk("w5_after_rst", mem_rdata, 64'd0);

        // Undefined opcode: no controls, no side effects
        drive(T_STUR, 64'h18, 64'h7777);
        drive(11'b00000000000, 64'h18, 64'h9999);
        chk("undef_ctl", {55'd0, dut_ctl()}, 64'd0);
        chk("undef_aluc", {60'd0, alu_ctrl}, 64'h2);
        chk("undef_rdata", mem_rdata, 64'd0);
        drive(T_LDUR, 64'h18, 64'h0);
        chk("undef_nowrite", mem_rdata, 64'h7777);

        drive(11'd0, 64'h0, 64'h0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
